// File: rtl/prince_pkg.sv
// Shared definitions for the masked PRINCE inverse-round sequencer.
//   STATE_W / NIB / SHARES : state width, nibbles per share, number of shares
//   RC                     : PRINCE round constants RC0..RC11
//   SR_INV                 : inverse ShiftRows, nibble positions counted from
//                            the MSB nibble (position 0 = bits [63:60])
//   seq_state_e            : sequencer FSM states
package prince_pkg;

   localparam int STATE_W = 64;
   localparam int NIB     = 16;
   localparam int SHARES  = 3;
   localparam int RC_BASE = 6;   // first inverse round uses RC6

   localparam logic [STATE_W-1:0] RC [12] = '{
      64'h0000000000000000, 64'h13198a2e03707344,
      64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
      64'h452821e638d01377, 64'hbe5466cf34e90c6c,
      64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa,
      64'hc882d32f25323c54, 64'h64a51195e0e3610d,
      64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
   };

   // out nibble p takes in nibble SR_INV[p]
   localparam int SR_INV [NIB] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_APPLY  = 2'd1,
      S_WAIT   = 2'd2,
      S_FINISH = 2'd3
   } seq_state_e;

endpackage

// File: rtl/prince_inv_mlayer.sv
// Inverse PRINCE linear layer M^-1 on one share: SR^-1 followed by M'.
//   din  : 64-bit share in
//   dout : 64-bit share out
// Purely combinational; linear, so it is applied to each share separately.
module prince_inv_mlayer
   import prince_pkg::*;
(
   input  logic [STATE_W-1:0] din,
   output logic [STATE_W-1:0] dout
);

   logic [STATE_W-1:0] sr;

   for (genvar p = 0; p < NIB; p++) begin : g_sr
      assign sr[STATE_W-1-4*p -: 4] = din[STATE_W-1-4*SR_INV[p] -: 4];
   end

   // M' is block-diagonal (M^0, M^1, M^1, M^0) over 16-bit chunks. Every
   // output bit is the parity of the same bit position across the chunk's four
   // nibbles with exactly one nibble left out; XOR-ing the left-out term back
   // into the full parity removes it.
   for (genvar c = 0; c < 4; c++) begin : g_chunk
      localparam int HAT = (c == 0 || c == 3) ? 0 : 1;
      localparam int CB  = STATE_W - 1 - 16*c;
      for (genvar j = 0; j < 4; j++) begin : g_nib
         for (genvar b = 0; b < 4; b++) begin : g_bit
            localparam int KX = (b - j - HAT + 8) % 4;
            assign dout[CB-4*j-b] = sr[CB-b] ^ sr[CB-4-b] ^ sr[CB-8-b] ^ sr[CB-12-b]
                                  ^ sr[CB-4*KX-b];
         end
      end
   end

endmodule

// File: rtl/prince_inv_round_seq.sv
// Sequencer for the masked inverse rounds R'6..R'(5+NROUNDS) of a 3-share
// PRINCE core. Each round: share 1 gets key1 ^ RC, every share goes through
// M^-1, the result is registered onto sbox_in*, and after the external lanes'
// latency the lane outputs are captured back into the state.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : run request, honoured only when idle
//   state_in1/2/3, key1   : input shares (sampled on accept), round key k1
//   busy, done            : run in progress / one-cycle completion pulse
//   state_out1/2/3        : result shares, valid with done and held after
//   sbox_in1/2/3          : registered shares to the 16 inverse S-box lanes
//   sbox_out1/2/3         : lane outputs
module prince_inv_round_seq
   import prince_pkg::*;
#(
   parameter int SBOX_LAT = 4,
   parameter int NROUNDS  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] state_in1,
   input  logic [STATE_W-1:0] state_in2,
   input  logic [STATE_W-1:0] state_in3,
   input  logic [STATE_W-1:0] key1,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] state_out1,
   output logic [STATE_W-1:0] state_out2,
   output logic [STATE_W-1:0] state_out3,
   output logic [STATE_W-1:0] sbox_in1,
   output logic [STATE_W-1:0] sbox_in2,
   output logic [STATE_W-1:0] sbox_in3,
   input  logic [STATE_W-1:0] sbox_out1,
   input  logic [STATE_W-1:0] sbox_out2,
   input  logic [STATE_W-1:0] sbox_out3
);

   localparam int RND_W  = (NROUNDS  > 1) ? $clog2(NROUNDS)  : 1;
   localparam int WCNT_W = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

   seq_state_e                       state_q, state_d;
   logic [RND_W-1:0]                 rnd_q, rnd_d;
   logic [WCNT_W-1:0]                wcnt_q, wcnt_d;
   logic                             load_in, load_sbox, capture, finish;
   logic                             busy_q, done_q;
   logic [SHARES-1:0][STATE_W-1:0]   st_q, sbin_q, sout_q, mix, mlay, lane_out;
   logic [3:0]                       rc_idx;

   assign rc_idx   = 4'(RC_BASE) + 4'(rnd_q);
   assign lane_out = {sbox_out3, sbox_out2, sbox_out1};

   // Key and round constant touch share 1 only; the other shares stay
   // independent so no two shares are ever combined.
   for (genvar g = 0; g < SHARES; g++) begin : g_share
      if (g == 0) begin : g_keyed
         assign mix[g] = st_q[g] ^ key1 ^ RC[rc_idx];
      end else begin : g_plain
         assign mix[g] = st_q[g];
      end
      prince_inv_mlayer u_mlayer (.din(mix[g]), .dout(mlay[g]));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rnd_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rnd_d     = rnd_q;
      wcnt_d    = wcnt_q;
      load_in   = 1'b0;
      load_sbox = 1'b0;
      capture   = 1'b0;
      finish    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // busy is still high in the done cycle, which keeps a held start
            // from being taken until the following cycle
            if (start && !busy_q) begin
               load_in = 1'b1;
               rnd_d   = '0;
               state_d = S_APPLY;
            end
         end
         S_APPLY: begin
            load_sbox = 1'b1;
            wcnt_d    = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            wcnt_d = wcnt_q + 1'b1;
            // sbox_in* is the lanes' input register, so their output is
            // ready after SBOX_LAT-1 further cycles
            if (wcnt_q == WCNT_W'(SBOX_LAT-1)) begin
               capture = 1'b1;
               if (rnd_q == RND_W'(NROUNDS-1)) begin
                  state_d = S_FINISH;
               end else begin
                  rnd_d   = rnd_q + 1'b1;
                  state_d = S_APPLY;
               end
            end
         end
         S_FINISH: begin
            finish  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= '0;
         sbin_q <= '0;
         sout_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= finish;
         if (load_in) begin
            st_q   <= {state_in3, state_in2, state_in1};
            busy_q <= 1'b1;
         end else if (state_q == S_IDLE) begin
            busy_q <= 1'b0;
         end
         if (load_sbox) sbin_q <= mlay;
         if (capture)   st_q   <= lane_out;
         if (finish)    sout_q <= st_q;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign state_out1 = sout_q[0];
   assign state_out2 = sout_q[1];
   assign state_out3 = sout_q[2];
   assign sbox_in1   = sbin_q[0];
   assign sbox_in2   = sbin_q[1];
   assign sbox_in3   = sbin_q[2];

endmodule

// File: tb/tb_prince_inv_round_seq.sv
// Bench for prince_inv_round_seq. Lanes are modelled as a masked inverse
// S-box (fresh random re-sharing, or none in ideal mode) with three register
// stages behind sbox_in*. Results are compared with an unmasked reference
// decryption of rounds R'6..R'10 built from the PRINCE block-matrix definition.
module tb_prince_inv_round_seq;

   localparam int LAT = 27;   // accept cycle -> done cycle
   localparam int PER = 28;   // accept-to-accept with start held high

   localparam logic [63:0] RCV [5] = '{
      64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
      64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399
   };
   localparam logic [3:0] SINV [16] = '{
      4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
      4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
   };
   // forward ShiftRows, MSB-nibble-first positions: new[i] = old[SR[i]]
   localparam int SR [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
   // M0..M3: identity with diagonal entry i cleared (entry 0 = nibble MSB)
   localparam logic [3:0] MBLK [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   logic        clk = 1'b0;
   logic        rst, start, busy, done;
   logic [63:0] state_in1, state_in2, state_in3, key1;
   logic [63:0] state_out1, state_out2, state_out3;
   logic [63:0] sbox_in1, sbox_in2, sbox_in3;
   logic [63:0] sbox_out1, sbox_out2, sbox_out3;
   int          checks = 0, errors = 0, cyc = 0;
   bit          lane_rand = 1'b0;
   logic [63:0] lp [3][3];

   prince_inv_round_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .state_in1(state_in1), .state_in2(state_in2), .state_in3(state_in3),
      .key1(key1), .busy(busy), .done(done),
      .state_out1(state_out1), .state_out2(state_out2), .state_out3(state_out3),
      .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3),
      .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [63:0] sinv64(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = SINV[x[4*i +: 4]];
      return y;
   endfunction

   function automatic logic [63:0] sr_inv(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[63-4*SR[i] -: 4] = x[63-4*i -: 4];
      return y;
   endfunction

   // M^0 row j col k = M_{(j+k)%4}; M^1 row j col k = M_{(j+k+1)%4}
   function automatic logic [63:0] m_prime(input logic [63:0] x);
      logic [63:0] y;
      logic [3:0]  acc;
      logic [1:0]  mi;
      int          hat;
      for (int c = 0; c < 4; c++) begin
         hat = (c == 1 || c == 2) ? 1 : 0;
         for (int j = 0; j < 4; j++) begin
            acc = 4'h0;
            for (int k = 0; k < 4; k++) begin
               mi  = 2'((j + k + hat) % 4);
               acc = acc ^ (x[63-16*c-4*k -: 4] & MBLK[mi]);
            end
            y[63-16*c-4*j -: 4] = acc;
         end
      end
      return y;
   endfunction

   function automatic logic [63:0] minv(input logic [63:0] x);
      return m_prime(sr_inv(x));
   endfunction

   function automatic logic [63:0] ref_dec(input logic [63:0] x, input logic [63:0] k);
      for (int r = 0; r < 5; r++) x = sinv64(minv(x ^ k ^ RCV[3'(r)]));
      return x;
   endfunction

   // ---------------- lane model ----------------
   always @(posedge clk) begin
      logic [63:0] y, r1, r2;
      y  = sinv64(sbox_in1 ^ sbox_in2 ^ sbox_in3);
      r1 = lane_rand ? {$urandom, $urandom} : 64'd0;
      r2 = lane_rand ? {$urandom, $urandom} : 64'd0;
      lp[0][0] <= y ^ r1 ^ r2;
      lp[0][1] <= r1;
      lp[0][2] <= r2;
      lp[1]    <= lp[0];
      lp[2]    <= lp[1];
   end
   assign sbox_out1 = lp[2][0];
   assign sbox_out2 = lp[2][1];
   assign sbox_out3 = lp[2][2];

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic launch(output int t);
      start = 1'b1;
      t = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int t, output int first, output int cnt, output logic bz);
      first = -1; cnt = 0; bz = 1'b0;
      while (cyc < t + LAT + 1) begin
         step();
         if (done === 1'b1) begin
            cnt++;
            if (first < 0) begin first = cyc; bz = busy; end
         end
      end
   endtask

   task automatic set_in(input logic [63:0] a, b, c, k);
      state_in1 = a; state_in2 = b; state_in3 = c; key1 = k;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int seen = 0;
      rst = 1'b1; start = 1'b1;
      set_in({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (3) begin
         step();
         if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL reset_ctrl got %0d busy/done cycles want 0", seen); end
      checks++;
      if ({state_out1, state_out2, state_out3} !== 192'd0) begin
         errors++; $display("FAIL reset_state_out got %h %h %h want 0", state_out1, state_out2, state_out3);
      end
      checks++;
      if ({sbox_in1, sbox_in2, sbox_in3} !== 192'd0) begin
         errors++; $display("FAIL reset_sbox_in got %h %h %h want 0", sbox_in1, sbox_in2, sbox_in3);
      end
      rst = 1'b0; start = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_timing_unmasked();
      int t, first, cnt;
      logic bz;
      logic [63:0] exp;
      lane_rand = 1'b0;
      set_in(64'd0, 64'd0, 64'd0, 64'd0);
      exp = ref_dec(64'd0, 64'd0);
      launch(t);
      wait_done(t, first, cnt, bz);
      checks++;
      if (first != t + LAT || cnt != 1) begin
         errors++; $display("FAIL unmasked_latency got %0d (%0d pulses) want %0d", first - t, cnt, LAT);
      end
      checks++;
      if (bz !== 1'b1) begin errors++; $display("FAIL busy_in_done got %b want 1", bz); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", busy); end
      checks++;
      if (state_out1 !== exp) begin errors++; $display("FAIL unmasked_out1 got %h want %h", state_out1, exp); end
      checks++;
      if ({state_out2, state_out3} !== 128'd0) begin
         errors++; $display("FAIL unmasked_out23 got %h %h want 0", state_out2, state_out3);
      end
   endtask

   task automatic test_masked();
      int t, first, cnt;
      logic bz;
      logic [63:0] s1, s2, s3, k, exp;
      lane_rand = 1'b1;
      for (int v = 0; v < 20; v++) begin
         s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom};
         s3 = {$urandom, $urandom}; k  = {$urandom, $urandom};
         set_in(s1, s2, s3, k);
         exp = ref_dec(s1 ^ s2 ^ s3, k);
         launch(t);
         step();   // round 0 APPLY result is on sbox_in*
         checks++;
         if (sbox_in2 !== minv(s2)) begin
            errors++; $display("FAIL probe_sbox_in2 v%0d got %h want %h", v, sbox_in2, minv(s2));
         end
         if (v == 0) begin
            checks++;
            if (sbox_in3 !== minv(s3)) begin
               errors++; $display("FAIL probe_sbox_in3 got %h want %h", sbox_in3, minv(s3));
            end
            checks++;
            if (sbox_in1 !== minv(s1 ^ k ^ RCV[0])) begin
               errors++; $display("FAIL probe_sbox_in1 got %h want %h", sbox_in1, minv(s1 ^ k ^ RCV[0]));
            end
         end
         wait_done(t, first, cnt, bz);
         checks++;
         if (first != t + LAT || cnt != 1) begin
            errors++; $display("FAIL masked_latency v%0d got %0d (%0d pulses) want %0d", v, first - t, cnt, LAT);
         end
         checks++;
         if ((state_out1 ^ state_out2 ^ state_out3) !== exp) begin
            errors++; $display("FAIL masked_result v%0d got %h want %h", v,
                               state_out1 ^ state_out2 ^ state_out3, exp);
         end
      end
   endtask

   task automatic test_ignored_start();
      int t, first = -1, cnt = 0;
      logic [63:0] s1, s2, s3, k, exp;
      s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom};
      s3 = {$urandom, $urandom}; k  = {$urandom, $urandom};
      set_in(s1, s2, s3, k);
      exp = ref_dec(s1 ^ s2 ^ s3, k);
      launch(t);
      while (cyc < t + LAT + 4) begin
         start = (cyc == t + 5 || cyc == t + 20);
         step();
         if (done === 1'b1) begin cnt++; if (first < 0) first = cyc; end
      end
      start = 1'b0;
      checks++;
      if (first != t + LAT || cnt != 1) begin
         errors++; $display("FAIL ignored_start_done got %0d (%0d pulses) want %0d", first - t, cnt, LAT);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_queued got busy %b want 0", busy); end
      checks++;
      if ((state_out1 ^ state_out2 ^ state_out3) !== exp) begin
         errors++; $display("FAIL ignored_start_result got %h want %h", state_out1 ^ state_out2 ^ state_out3, exp);
      end
   endtask

   task automatic test_reset_midrun();
      int t, t2, first, cnt = 0, cnt2;
      logic bz;
      logic [63:0] s1, s2, s3, k, exp;
      s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom};
      s3 = {$urandom, $urandom}; k  = {$urandom, $urandom};
      set_in(s1, s2, s3, k);
      exp = ref_dec(s1 ^ s2 ^ s3, k);
      launch(t);
      while (cyc < t + 12) begin step(); if (done === 1'b1) cnt++; end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL midrun_ctrl got busy %b done %b want 0 0", busy, done);
      end
      checks++;
      if ({sbox_in1, sbox_in2, sbox_in3, state_out1, state_out2, state_out3} !== 384'd0) begin
         errors++; $display("FAIL midrun_clear got %h %h %h want 0", sbox_in1, sbox_in2, sbox_in3);
      end
      while (cyc < t + 15) begin step(); if (done === 1'b1) cnt++; end
      launch(t2);
      wait_done(t2, first, cnt2, bz);
      checks++;
      if (cnt != 0 || first != t + 42 || cnt2 != 1) begin
         errors++; $display("FAIL midrun_timing got done at %0d (%0d aborted, %0d new) want %0d", first - t, cnt, cnt2, 42);
      end
      checks++;
      if ((state_out1 ^ state_out2 ^ state_out3) !== exp) begin
         errors++; $display("FAIL midrun_result got %h want %h", state_out1 ^ state_out2 ^ state_out3, exp);
      end
   endtask

   task automatic test_back_to_back();
      int t, nd = 0;
      int dcyc [3];
      logic [63:0] got [3];
      logic [63:0] v [3][3];
      logic [63:0] k;
      k = {$urandom, $urandom};
      for (int i = 0; i < 3; i++)
         for (int s = 0; s < 3; s++) v[i][s] = {$urandom, $urandom};
      set_in(v[0][0], v[0][1], v[0][2], k);
      start = 1'b1;
      t = cyc;
      while (cyc < t + 2*PER + LAT + 1) begin
         step();
         if (cyc == t + 1)       set_in(v[1][0], v[1][1], v[1][2], k);
         if (cyc == t + PER + 1) set_in(v[2][0], v[2][1], v[2][2], k);
         if (cyc == t + 2*PER + 1) start = 1'b0;
         if (done === 1'b1) begin
            if (nd < 3) begin
               dcyc[nd] = cyc;
               got[nd]  = state_out1 ^ state_out2 ^ state_out3;
            end
            nd++;
         end
      end
      start = 1'b0;
      checks++;
      if (nd != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nd); end
      for (int i = 0; i < 3 && i < nd; i++) begin
         checks++;
         if (dcyc[i] != t + LAT + i*PER) begin
            errors++; $display("FAIL b2b_done%0d got %0d want %0d", i, dcyc[i] - t, LAT + i*PER);
         end
         checks++;
         if (got[i] !== ref_dec(v[i][0] ^ v[i][1] ^ v[i][2], k)) begin
            errors++; $display("FAIL b2b_result%0d got %h want %h", i, got[i],
                               ref_dec(v[i][0] ^ v[i][1] ^ v[i][2], k));
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      set_in(64'd0, 64'd0, 64'd0, 64'd0);
      test_reset();
      test_timing_unmasked();
      test_masked();
      test_ignored_start();
      test_reset_midrun();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prince_inv_round_seq.md
Name: prince_inv_round_seq

Overview:
- Sequences the five masked inverse rounds R'6..R'10 of the 3-share, second-order masked PRINCE core.
- Holds the 64-bit shared state (three 64-bit shares).
- Each round: adds round key and round constant, applies the inverse linear layer M^-1 (SR^-1, then M'), drives the 16 external 4-bit masked inverse S-box lanes, waits out their pipeline latency, then captures the result.
- Sits directly upstream of the inverse S-box lanes, which are instantiated outside this block, and consumes their outputs.

Parameters:
- SBOX_LAT, 4, clock cycles from sbox_in* valid to sbox_out* valid in the external inverse S-box lanes (input register plus three Q294 stages).
- NROUNDS, 5, number of inverse rounds; constants are RC6..RC(5+NROUNDS).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- state_in1/2/3  in  64 each  input shares; sampled when start is accepted
- key1  in  64  round key k1; added to share 1 only; must be stable while busy
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
- done  out  1  one-cycle pulse; state_out* valid
- state_out1/2/3  out  64 each  result shares; held until the next accepted start
- sbox_in1/2/3  out  64 each  registered shares to the lanes; nibble i feeds lane i
- sbox_out1/2/3  in  64 each  lane outputs

Behaviour:
- Reset: all outputs 0, including busy, done, state_out* and sbox_in*. FSM returns to IDLE; round counter = 0; wait counter = 0.
- FSM states: IDLE, APPLY, WAIT, FINISH.
- IDLE:
  - On start=1, register state_in1/2/3 into st1/2/3, set rnd=0, go to APPLY.
  - start in any other state is ignored; no queuing.
- APPLY (1 cycle):
  - sbox_in1 <= M^-1(st1 ^ key1 ^ RC[6+rnd]).
  - sbox_in2 <= M^-1(st2); sbox_in3 <= M^-1(st3).
  - Clear wcnt; go to WAIT.
- WAIT:
  - Increment wcnt each cycle.
  - When wcnt == SBOX_LAT-1: capture st* <= sbox_out*.
  - If rnd == NROUNDS-1, go to FINISH; else rnd++ and go to APPLY.
- FINISH (1 cycle):
  - state_out* <= st*; done=1; go to IDLE.
  - busy falls the cycle after done.
- Latency: start accepted at cycle t, done asserted at cycle t+1+NROUNDS*(1+SBOX_LAT)+1. With defaults this is t+27.
- sbox_in* hold their value throughout WAIT. The lanes are free-running pipelines, so no valid strobe is needed.
- M^-1 is linear, so it is applied per share. Key and RC enter share 1 only; shares 2 and 3 are never combined with each other or with share 1.
- RC constants:
  - RC6 7ef84f78fd955cb1
  - RC7 85840851f1ac43aa
  - RC8 c882d32f25323c54
  - RC9 64a51195e0e3610d
  - RC10 d3b5a399ca0c2399
- Reset asserted mid-run: the run is aborted in that cycle. Outputs go to reset values next edge; no done pulse.
- Nibble order: nibble 0 = bits [3:0]. SR^-1 uses the PRINCE state layout with nibble 15 as the MSB.

Decomposition:
- Shared package prince_pkg holds:
  - the RC table (64-bit array indexed 0..11)
  - the FSM state enum
  - width constants: STATE_W=64, NIB=16, SHARES=3
- One combinational sub-module, prince_inv_mlayer: 64-bit in, 64-bit out, SR^-1 followed by M'. The block instantiates it 3 times, once per share.

Test Plan:
- Reset check: hold rst for 3 cycles, with start=1 during reset -> all outputs 0, busy=0, no done pulse.
- Timing, unmasked: shares 2 and 3 = 0; state_in1=0, key1=0; bench models lanes as ideal S^-1 with a 4-cycle delay -> done at t+27, and state_out1 equals the software model of R'10..R'6 applied to 0; state_out2 and state_out3 = 0.
- Masked correctness: real masked lanes fed random r, random shares and random key (20 vectors) -> XOR of state_out* matches the unmasked model every time. Also, probing sbox_in2 in APPLY of round 0 shows M^-1(state_in2) exactly, with no key or RC mixed in.
- Ignored start: pulse start=1 at t+5 and t+20 during a run -> single done at t+27, and the result is unaffected.
- Reset mid-run: assert rst at t+12 for 1 cycle -> busy=0, sbox_in*=0 next cycle, and no done. A new start at t+15 completes at t+42 with the correct result.
- Back-to-back: start held high continuously -> runs accepted at t, t+28, t+56, each producing its own done and correct state_out*.
